// File: rtl/dice_pkg.sv
// Shared 7-segment face tables and monitor state encoding for the dice blocks.
package dice_pkg;

    localparam int FACE_W = 3;
    typedef logic [FACE_W-1:0] face_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_FACE1 = 7'h06;
    localparam logic [6:0] SEG_FACE2 = 7'h5B;
    localparam logic [6:0] SEG_FACE3 = 7'h4F;
    localparam logic [6:0] SEG_FACE4 = 7'h66;
    localparam logic [6:0] SEG_FACE5 = 7'h6D;
    localparam logic [6:0] SEG_FACE6 = 7'h7D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_face.sv
// Combinational 7-segment decoder: pattern -> {valid, blank, face}.
module seg7_to_face
    import dice_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output face_t      face
);

    // Table lookup; anything not a face or blank is flagged invalid with face 0
    always_comb begin
        valid = 1'b1;
        blank = 1'b0;
        face  = '0;
        case (seg)
            SEG_FACE1: face = face_t'(1);
            SEG_FACE2: face = face_t'(2);
            SEG_FACE3: face = face_t'(3);
            SEG_FACE4: face = face_t'(4);
            SEG_FACE5: face = face_t'(5);
            SEG_FACE6: face = face_t'(6);
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/dice_face_monitor.sv
// Watches the dice 7-segment lines, qualifies stable patterns and keeps
// saturating roll / error / per-face statistics.
module dice_face_monitor
    import dice_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1000,
    parameter int CNT_W          = 16,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         seg,
    input  logic               clr,
    output face_t              face,
    output logic               roll_pulse,
    output logic               err_pulse,
    output logic               busy,
    output logic [CNT_W-1:0]   roll_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [6*CNT_W-1:0] hist
);

    localparam int                STAB_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [6:0]        seg_in;
    logic [6:0]        seg_q;
    logic [STAB_W-1:0] stab;
    logic              changed;
    logic              dec_valid;
    logic              dec_blank;
    face_t             dec_face;
    state_t            state;
    state_t            state_n;
    logic              settle_ok;
    logic              settle_err;

    assign seg_in  = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    assign changed = (seg_in != seg_q);
    assign busy    = (state == ST_TRACK);

    // Decode the registered pattern: at the settle point seg_in == seg_q anyway
    seg7_to_face u_dec (
        .seg   (seg_q),
        .valid (dec_valid),
        .blank (dec_blank),
        .face  (dec_face)
    );

    // Input sample register and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            stab  <= '0;
        end else begin
            seg_q <= seg_in;
            if (changed)
                stab <= '0;
            else if (stab != STAB_MAX)
                stab <= stab + STAB_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next state and settle events; a change always overrides a settle
    always_comb begin
        state_n    = state;
        settle_ok  = 1'b0;
        settle_err = 1'b0;
        if (changed) begin
            state_n = (seg_in == SEG_BLANK) ? ST_IDLE : ST_TRACK;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (stab == STAB_LAST) begin
                        state_n = ST_DONE;
                        if (dec_valid)
                            settle_ok = 1'b1;
                        else if (!dec_blank)
                            settle_err = 1'b1;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // Registered pulses and last settled face
    always_ff @(posedge clk) begin
        if (rst) begin
            roll_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            face       <= '0;
        end else begin
            roll_pulse <= settle_ok;
            err_pulse  <= settle_err;
            if (settle_ok)
                face <= dec_face;
        end
    end

    // Roll and error counters; clr beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            roll_count <= '0;
            err_count  <= '0;
        end else begin
            if (settle_ok && roll_count != CNT_MAX)
                roll_count <= roll_count + CNT_W'(1);
            if (settle_err && err_count != CNT_MAX)
                err_count <= err_count + CNT_W'(1);
        end
    end

    // Per-face histogram bins, face f lives at index f-1
    for (genvar g = 0; g < 6; g++) begin : g_hist
        logic [CNT_W-1:0] bin;

        // One saturating bin per face value
        always_ff @(posedge clk) begin
            if (rst || clr)
                bin <= '0;
            else if (settle_ok && dec_face == face_t'(g + 1) && bin != CNT_MAX)
                bin <= bin + CNT_W'(1);
        end

        assign hist[g*CNT_W +: CNT_W] = bin;
    end

endmodule

// File: tb/tb_dice_face_monitor.sv
// Scoreboard bench for dice_face_monitor (STABLE_CYCLES=4, CNT_W=3).
module tb_dice_face_monitor;

    localparam int SC = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg;
    logic          clr;
    logic [2:0]    face;
    logic          roll_pulse;
    logic          err_pulse;
    logic          busy;
    logic [CW-1:0] roll_count;
    logic [CW-1:0] err_count;
    logic [6*CW-1:0] hist;

    typedef struct {
        int kind;   // 1 = roll, 2 = error
        int face;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dice_face_monitor #(
        .STABLE_CYCLES  (SC),
        .CNT_W          (CW),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .clr        (clr),
        .face       (face),
        .roll_pulse (roll_pulse),
        .err_pulse  (err_pulse),
        .busy       (busy),
        .roll_count (roll_count),
        .err_count  (err_count),
        .hist       (hist)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int hget(input int f);
        return int'(hist[(f-1)*CW +: CW]);
    endfunction

    task automatic push(input int kind, input int f);
        exp_t e;
        e.kind = kind;
        e.face = f;
        e.cyc  = cyc + SC + 1;
        exp_q.push_back(e);
    endtask

    // Output monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        if (roll_pulse || err_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", roll_pulse ? 1 : 2, e.kind);
                chk("both_pulses", int'(roll_pulse & err_pulse), 0);
                chk("pulse_face", int'(face), e.face);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        seg = 7'h4F;
        clr = 1'b0;

        // Reset with a face already on the lines
        repeat (3) begin
            @(negedge clk);
            chk("rst_face", int'(face), 0);
            chk("rst_roll_pulse", int'(roll_pulse), 0);
            chk("rst_err_pulse", int'(err_pulse), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_roll_count", int'(roll_count), 0);
            chk("rst_err_count", int'(err_count), 0);
            chk("rst_hist", int'(hist), 0);
        end
        rst = 1'b0;
        push(1, 3);

        // Face 3 qualifies and is held well past settling
        @(negedge clk);
        chk("pre_settle_face", int'(face), 0);
        chk("pre_settle_hist", int'(hist), 0);
        chk("pre_settle_busy", int'(busy), 1);
        repeat (9) @(negedge clk);
        chk("t2_face", int'(face), 3);
        chk("t2_hist3", hget(3), 1);
        chk("t2_roll_count", int'(roll_count), 1);
        chk("t2_busy_done", int'(busy), 0);

        // Fast toggling never settles
        for (int i = 0; i < 20; i++) begin
            seg = (i % 2 == 0) ? 7'h06 : 7'h5B;
            repeat (2) begin
                @(negedge clk);
                chk("t3_busy", int'(busy), 1);
            end
        end
        chk("t3_roll_count", int'(roll_count), 1);
        chk("t3_err_count", int'(err_count), 0);
        chk("t3_face", int'(face), 3);

        // Invalid pattern settles as an error
        seg = 7'h7F;
        push(2, 3);
        repeat (8) @(negedge clk);
        chk("t4_err_count", int'(err_count), 1);
        chk("t4_face", int'(face), 3);
        chk("t4_hist3", hget(3), 1);
        chk("t4_roll_count", int'(roll_count), 1);
        seg = 7'h00;
        @(negedge clk);
        chk("t4_blank_busy", int'(busy), 0);
        repeat (6) @(negedge clk);
        chk("t4_blank_err_count", int'(err_count), 1);

        // Clear statistics
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_roll_count", int'(roll_count), 0);
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_hist", int'(hist), 0);

        // Nine face-6 rolls saturate the 3-bit counters
        for (int i = 0; i < 9; i++) begin
            seg = 7'h7D;
            push(1, 6);
            repeat (6) @(negedge clk);
            seg = 7'h00;
            repeat (2) @(negedge clk);
        end
        chk("t5_hist6", hget(6), 7);
        chk("t5_roll_count", int'(roll_count), 7);
        for (int f = 1; f <= 5; f++) chk("t5_other_bin", hget(f), 0);

        // Another bin still counts while roll_count sits at max
        seg = 7'h06;
        push(1, 1);
        repeat (6) @(negedge clk);
        seg = 7'h00;
        repeat (2) @(negedge clk);
        chk("sat_hist1", hget(1), 1);
        chk("sat_hist6", hget(6), 7);
        chk("sat_roll_count", int'(roll_count), 7);
        chk("sat_face", int'(face), 1);

        // clr coincides with the settle edge of a face-2 roll
        seg = 7'h5B;
        push(1, 2);
        repeat (SC) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t6_roll_pulse", int'(roll_pulse), 1);
        chk("t6_face", int'(face), 2);
        chk("t6_roll_count", int'(roll_count), 0);
        chk("t6_err_count", int'(err_count), 0);
        chk("t6_hist", int'(hist), 0);
        @(negedge clk);
        chk("t6_pulse_single", int'(roll_pulse), 0);

        // Reset in the middle of qualification
        seg = 7'h00;
        repeat (2) @(negedge clk);
        seg = 7'h6D;
        repeat (2) @(negedge clk);
        chk("t6_track_busy", int'(busy), 1);
        rst = 1'b1;
        seg = 7'h00;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_face", int'(face), 0);
        chk("t6_rst_busy", int'(busy), 0);
        repeat (6) @(negedge clk);
        chk("t6_rst_roll_count", int'(roll_count), 0);
        chk("t6_rst_face_after", int'(face), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
